// File: rtl/clahe_hist_bank_ctrl.sv
// Ping-pong histogram bank sequencer: flips the statistics bank on frame start,
// zero-fills it through RAM port A, and hands finished banks to the clipper.
module clahe_hist_bank_ctrl #(
  parameter int TILE_NUM_BITS = 6,
  parameter int BIN_W         = 16
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     frame_end,
  output logic                     ping_pong_flag,
  output logic                     clear_done,
  output logic                     clr_wr_en,
  output logic                     clr_bank,
  output logic [TILE_NUM_BITS-1:0] clr_tile_idx,
  output logic [7:0]               clr_addr,
  output logic [BIN_W-1:0]         clr_data,
  output logic                     clip_start,
  output logic                     clip_bank,
  input  logic                     clip_done,
  output logic                     err_overrun,
  input  logic                     err_clr
);

  localparam int CW = TILE_NUM_BITS + 8;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_CLIP, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic            clear_done_q, clear_done_d;
  logic            clr_wr_en_q, clr_wr_en_d;
  logic            clr_bank_q, clr_bank_d;
  logic            clip_start_q, clip_start_d;
  logic            clip_bank_q, clip_bank_d;
  logic            clip_busy_q, clip_busy_d;
  logic            err_q, err_d;
  logic            err_set;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
      clear_done_q <= 1'b0;
      clr_wr_en_q  <= 1'b0;
      clr_bank_q   <= 1'b0;
      clip_start_q <= 1'b0;
      clip_bank_q  <= 1'b0;
      clip_busy_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      clear_done_q <= clear_done_d;
      clr_wr_en_q  <= clr_wr_en_d;
      clr_bank_q   <= clr_bank_d;
      clip_start_q <= clip_start_d;
      clip_bank_q  <= clip_bank_d;
      clip_busy_q  <= clip_busy_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flag_d       = flag_q;
    clear_done_d = clear_done_q;
    clr_wr_en_d  = clr_wr_en_q;
    clr_bank_d   = clr_bank_q;
    clip_start_d = 1'b0;
    clip_bank_d  = clip_bank_q;
    clip_busy_d  = clip_busy_q;
    err_set      = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          flag_d       = ~flag_q;
          clear_done_d = 1'b0;
          clr_bank_d   = ~flag_q;
          // A same-cycle clip_done releases the bank, so no stall is needed.
          if (clip_busy_q && !clip_done && (clip_bank_q == ~flag_q)) begin
            state_d = WAIT_CLIP;
            err_set = 1'b1;
          end else begin
            state_d     = CLEAR;
            clr_wr_en_d = 1'b1;
          end
        end
      end
      WAIT_CLIP: begin
        if (frame_start) err_set = 1'b1;
        if (clip_done) begin
          state_d     = CLEAR;
          clr_wr_en_d = 1'b1;
        end
      end
      CLEAR: begin
        if (frame_start) err_set = 1'b1;
        if (cnt_q == CNT_MAX) begin
          cnt_d        = '0;
          state_d      = IDLE;
          clear_done_d = 1'b1;
          clr_wr_en_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clip_done) clip_busy_d = 1'b0;
    if (frame_end) begin
      if (!clear_done_q) err_set = 1'b1;
      if (!clip_busy_q || clip_done) begin
        clip_start_d = 1'b1;
        clip_bank_d  = flag_q;
        clip_busy_d  = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  assign ping_pong_flag = flag_q;
  assign clear_done     = clear_done_q;
  assign clr_wr_en      = clr_wr_en_q;
  assign clr_bank       = clr_bank_q;
  assign clr_tile_idx   = cnt_q[CW-1:8];
  assign clr_addr       = cnt_q[7:0];
  assign clr_data       = '0;
  assign clip_start     = clip_start_q;
  assign clip_bank      = clip_bank_q;
  assign err_overrun    = err_q;

endmodule

// File: tb/tb_clahe_hist_bank_ctrl.sv
// Scoreboard bench: event-level reference model queues expected clear writes and
// clip starts; a negedge monitor pops and compares them and the status outputs.
module tb_clahe_hist_bank_ctrl;
  localparam int TNB = 2;
  localparam int N   = 1 << (TNB + 8);

  logic           pclk = 1'b0;
  logic           rst  = 1'b1;
  logic           frame_start = 1'b0, frame_end = 1'b0, clip_done = 1'b0, err_clr = 1'b0;
  logic           ping_pong_flag, clear_done, clr_wr_en, clr_bank, clip_start, clip_bank, err_overrun;
  logic [TNB-1:0] clr_tile_idx;
  logic [7:0]     clr_addr;
  logic [15:0]    clr_data;

  clahe_hist_bank_ctrl #(.TILE_NUM_BITS(TNB), .BIN_W(16)) dut (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .ping_pong_flag(ping_pong_flag), .clear_done(clear_done), .clr_wr_en(clr_wr_en),
    .clr_bank(clr_bank), .clr_tile_idx(clr_tile_idx), .clr_addr(clr_addr),
    .clr_data(clr_data), .clip_start(clip_start), .clip_bank(clip_bank),
    .clip_done(clip_done), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    bit flag, busy, cbank, err, cd, waiting, wbank;
    int clear_last;
  } model_t;
  typedef struct { bit b; int a; int c; } wr_t;
  typedef struct { bit b; int c; } clip_t;

  model_t cur, nx;
  wr_t    wq[$];
  clip_t  cq[$];
  int     n_cmp = 0, n_bad = 0;

  function automatic model_t model_reset();
    model_t m;
    m = '{flag: 0, busy: 0, cbank: 0, err: 0, cd: 0, waiting: 0, wbank: 0, clear_last: -1};
    return m;
  endfunction

  task automatic push_clear(input int c, input bit b);
    nx.clear_last = c + N;
    for (int i = 0; i < N; i++) wq.push_back('{b: b, a: i, c: c + 1 + i});
  endtask

  // One clock cycle of stimulus; the model's reaction becomes visible next cycle.
  task automatic step(input bit fs, input bit fe, input bit cd, input bit ec);
    bit set, busy_eff;
    int c;
    @(posedge pclk); #1;
    c = cyc;
    if (nx.clear_last >= 0 && c == nx.clear_last + 1) nx.cd = 1;
    cur = nx;
    frame_start = fs; frame_end = fe; clip_done = cd; err_clr = ec;
    set = 0;
    busy_eff = cur.busy && !cd;
    if (fs) begin
      if (c <= cur.clear_last || cur.waiting) set = 1;
      else begin
        nx.flag = ~cur.flag;
        nx.cd   = 0;
        if (busy_eff && cur.cbank == nx.flag) begin
          nx.waiting = 1; nx.wbank = nx.flag; set = 1;
        end else push_clear(c, nx.flag);
      end
    end
    if (cd) begin
      nx.busy = 0;
      if (cur.waiting) begin
        nx.waiting = 0;
        push_clear(c, cur.wbank);
      end
    end
    if (fe) begin
      if (!cur.cd) set = 1;
      if (!busy_eff) begin
        cq.push_back('{b: cur.flag, c: c + 1});
        nx.busy = 1; nx.cbank = cur.flag;
      end else set = 1;
    end
    nx.err = set ? 1'b1 : (ec ? 1'b0 : cur.err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge pclk); #1;
    rst = 1;
    frame_start = 0; frame_end = 0; clip_done = 0; err_clr = 0;
    cur = model_reset(); nx = cur;
    wq.delete(); cq.delete();
    @(posedge pclk); #1;
    rst = 0;
  endtask

  always @(negedge pclk) begin
    automatic logic [4:0] act = {ping_pong_flag, clear_done, err_overrun, clip_bank, |clr_data};
    automatic logic [4:0] exp = {cur.flag, cur.cd, cur.err, cur.cbank, 1'b0};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL status cyc=%0d {flag,cd,err,clip_bank,data!=0} got=%b want=%b", cyc, act, exp);
    end
    if (rst && (clr_wr_en || clip_start)) begin
      n_cmp++; n_bad++;
      $display("FAIL reset_strobe cyc=%0d wr=%b clip_start=%b want 0", cyc, clr_wr_en, clip_start);
    end
    if (clr_wr_en === 1'b1) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write cyc=%0d bank=%0d addr=%0d", cyc, clr_bank, {clr_tile_idx, clr_addr});
      end else begin
        automatic wr_t w = wq.pop_front();
        if (w.b !== clr_bank || w.a != int'({clr_tile_idx, clr_addr}) || w.c != cyc) begin
          n_bad++;
          $display("FAIL clear_write got bank=%0d addr=%0d cyc=%0d want bank=%0d addr=%0d cyc=%0d",
                   clr_bank, {clr_tile_idx, clr_addr}, cyc, w.b, w.a, w.c);
        end
      end
    end else if (wq.size() > 0 && wq[0].c <= cyc) begin
      automatic wr_t w = wq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_write cyc=%0d got none want bank=%0d addr=%0d", cyc, w.b, w.a);
    end
    if (clip_start === 1'b1) begin
      n_cmp++;
      if (cq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_clip_start cyc=%0d bank=%0d", cyc, clip_bank);
      end else begin
        automatic clip_t k = cq.pop_front();
        if (k.b !== clip_bank || k.c != cyc) begin
          n_bad++;
          $display("FAIL clip_start got bank=%0d cyc=%0d want bank=%0d cyc=%0d", clip_bank, cyc, k.b, k.c);
        end
      end
    end else if (cq.size() > 0 && cq[0].c <= cyc) begin
      automatic clip_t k = cq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_clip_start cyc=%0d got none want bank=%0d", cyc, k.b);
    end
  end

  initial begin
    cur = model_reset(); nx = cur;
    do_reset();
    // 1: basic clear of bank 1
    step(1, 0, 0, 0); idle(N + 6);
    // 2: clip handoff with idle clipper, then clear of bank 0 without a wait
    step(0, 1, 0, 0); idle($urandom_range(3, 20)); step(0, 0, 1, 0); idle(4);
    step(1, 0, 0, 0); idle(N + 6);
    // 3: clipper still on bank 0 when bank 0 comes round again
    step(0, 1, 0, 0); step(1, 0, 0, 0); idle(N + 6);
    step(1, 0, 0, 0); idle(49); step(0, 0, 1, 0); idle(N + 6);
    step(0, 0, 0, 1); idle(2);
    // 4: clip_done coincident with the conflicting frame_start
    step(0, 1, 0, 0); step(1, 0, 0, 0); idle(N + 6);
    step(1, 0, 1, 0); idle(N + 6);
    // 5: frame_start mid-clear, error clear, error set beating err_clr
    step(1, 0, 0, 0); idle(498); step(1, 0, 0, 0); idle(N);
    step(0, 0, 0, 1); idle(2);
    step(1, 0, 0, 0); idle(10); step(1, 0, 0, 1); idle(N);
    // 6: reset in the middle of a clear, then restart on bank 1
    step(1, 0, 0, 0); idle(298); do_reset();
    step(1, 0, 0, 0); idle(N + 6);
    // randomized event mix
    for (int i = 0; i < 8000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 249) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 59) == 0);
    idle(N + 10);
    n_cmp++;
    if (wq.size() != 0 || cq.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending writes=%0d clips=%0d want 0/0", wq.size(), cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
